// File: rtl/dma_pkg.sv
// Shared types and defaults for the DMA bus master.
package dma_pkg;
  localparam int DMA_WORD_SIZE = 16;
  localparam int DMA_LEN_W     = 5;

  localparam logic DIR_DEV2MEM = 1'b0;
  localparam logic DIR_MEM2DEV = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WR,
    RD_A,
    RD_D,
    DONE
  } dma_state_e;
endpackage

// File: rtl/dma_bus_master.sv
// Bus-master side of memory port 2: moves a block of words between a device buffer and
// memory after winning the bus through BR/BG, then pulses cmd_done.
//
//   state | meaning
//   IDLE  | waiting for cmd_start
//   REQ   | BR high, waiting for BG
//   WR    | device -> memory, one word per valid cycle
//   RD_A  | memory read address phase
//   RD_D  | memory read data phase, word handed to the device next cycle
//   DONE  | one-cycle completion pulse, bus released
module dma_bus_master
  import dma_pkg::*;
#(
  parameter int WORD_SIZE = DMA_WORD_SIZE,
  parameter int LEN_W     = DMA_LEN_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_start,
  input  logic                 cmd_dir,
  input  logic [WORD_SIZE-1:0] cmd_addr,
  input  logic [LEN_W-1:0]     cmd_len,
  output logic                 BR,
  input  logic                 BG,
  output logic                 readM2,
  output logic                 writeM2,
  output logic [WORD_SIZE-1:0] address2,
  inout  wire  [WORD_SIZE-1:0] data2,
  input  logic [WORD_SIZE-1:0] dev_rdata,
  input  logic                 dev_valid,
  output logic                 dev_pop,
  output logic [WORD_SIZE-1:0] dev_wdata,
  output logic                 dev_we,
  output logic                 cmd_done,
  output logic                 busy
);

  dma_state_e           state_q, state_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic                 dir_q, dir_d;
  logic                 act_q, act_d;
  logic                 done_q, done_d;
  logic                 we_q, we_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;

  // Strobes are gated by BG combinationally so a revoked grant silences the bus at once.
  assign writeM2  = (state_q == WR) & act_q & BG & dev_valid;
  assign readM2   = ((state_q == RD_A) | (state_q == RD_D)) & act_q & BG;
  assign address2 = (readM2 | writeM2) ? addr_q : '0;
  assign data2    = writeM2 ? dev_rdata : {WORD_SIZE{1'bz}};
  assign dev_pop  = writeM2;

  assign BR        = act_q;
  assign busy      = act_q;
  assign cmd_done  = done_q;
  assign dev_we    = we_q;
  assign dev_wdata = wdata_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          addr_d  = cmd_addr;
          cnt_d   = cmd_len;
          dir_d   = cmd_dir;
          state_d = (cmd_len == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        if (BG) state_d = (dir_q == DIR_MEM2DEV) ? RD_A : WR;
      end
      WR: begin
        if (!BG) begin
          state_d = REQ;
        end else if (dev_valid) begin
          addr_d = addr_q + WORD_SIZE'(1);
          cnt_d  = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = DONE;
        end
      end
      RD_A: begin
        state_d = BG ? RD_D : REQ;
      end
      RD_D: begin
        if (!BG) begin
          state_d = REQ;
        end else begin
          wdata_d = data2;
          we_d    = 1'b1;
          addr_d  = addr_q + WORD_SIZE'(1);
          cnt_d   = cnt_q - LEN_W'(1);
          state_d = (cnt_q == LEN_W'(1)) ? DONE : RD_A;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    act_d  = (state_d == REQ) | (state_d == WR) | (state_d == RD_A) | (state_d == RD_D);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_DEV2MEM;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      act_q   <= act_d;
      done_q  <= done_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_dma_bus_master.sv
// Self-checking bench for dma_bus_master: the bench plays memory, device and bus arbiter,
// and compares every transfer against the words the command should have moved.
module tb_dma_bus_master;
  import dma_pkg::*;

  logic        clk, reset_n, cmd_start, cmd_dir, BG, dev_valid;
  logic [15:0] cmd_addr, dev_rdata, address2, dev_wdata, mem_q;
  logic [4:0]  cmd_len;
  logic        BR, readM2, writeM2, dev_pop, dev_we, cmd_done, busy;
  wire  [15:0] data2;

  int errors = 0;
  int checks = 0;

  dma_bus_master #(.WORD_SIZE(16), .LEN_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_dir(cmd_dir),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .BR(BR), .BG(BG), .readM2(readM2),
    .writeM2(writeM2), .address2(address2), .data2(data2), .dev_rdata(dev_rdata),
    .dev_valid(dev_valid), .dev_pop(dev_pop), .dev_wdata(dev_wdata), .dev_we(dev_we),
    .cmd_done(cmd_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Untouched memory locations hold a fixed pattern; words 0..2 are the read-test image.
  function automatic logic [15:0] init_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h9023;
      16'h0001: return 16'h0001;
      16'h0002: return 16'hFFFF;
      default:  return (a ^ 16'h5A5A) + {a[7:0], a[15:8]};
    endcase
  endfunction

  logic [15:0] mem    [0:65535];
  bit          wvalid [0:65535];
  logic [15:0] src    [0:1023];
  int          src_idx = 0;

  assign dev_rdata = src[src_idx[9:0]];
  assign data2     = (readM2 && !writeM2) ? mem_q : 16'hzzzz;

  always @(posedge clk) begin
    if (writeM2) begin
      mem[address2]    <= data2;
      wvalid[address2] <= 1'b1;
    end
    if (readM2) mem_q <= wvalid[address2] ? mem[address2] : init_word(address2);
    if (dev_pop) src_idx <= src_idx + 1;
  end

  // Event log sampled mid-cycle.
  int          cyc = 0, wr_n = 0, we_n = 0, done_n = 0, br_n = 0, viol = 0, start_cyc = 0;
  logic [15:0] wr_addr [0:1023];
  logic [15:0] wr_data [0:1023];
  int          wr_cyc  [0:1023];
  logic [15:0] we_data [0:1023];
  int          we_cyc  [0:1023];
  int          done_cyc[0:63];
  logic        done_br [0:63];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (writeM2) begin
      wr_addr[wr_n] <= address2;
      wr_data[wr_n] <= data2;
      wr_cyc[wr_n]  <= cyc;
      wr_n          <= wr_n + 1;
    end
    if (dev_we) begin
      we_data[we_n] <= dev_wdata;
      we_cyc[we_n]  <= cyc;
      we_n          <= we_n + 1;
    end
    if (cmd_done) begin
      done_cyc[done_n] <= cyc;
      done_br[done_n]  <= BR;
      done_n           <= done_n + 1;
    end
    if (cmd_start) start_cyc <= cyc;
    if (BR) br_n <= br_n + 1;
    if ((readM2 && writeM2) || ((readM2 || writeM2) && !(BR && BG)) ||
        (dev_pop !== writeM2) || (writeM2 && !dev_valid))
      viol <= viol + 1;
  end

  bit tmo_g;
  int brdrop_bad_g;

  // Issues one command and plays arbiter/device until cmd_done or the cycle budget runs out.
  task automatic run_xfer(input logic dir, input logic [15:0] addr, input int len, input int lat,
                          input int vmode, input int drop_at, input int drop_len, input bit spur);
    int gcnt, dleft, wb, wbase, db;
    bit dropped;
    wb = wr_n; wbase = we_n; db = done_n;
    gcnt = 0; dleft = 0; dropped = 0; tmo_g = 1; brdrop_bad_g = 0;
    @(posedge clk); #1;
    cmd_start = 1; cmd_dir = dir; cmd_addr = addr; cmd_len = 5'(len); BG = 0; dev_valid = 0;
    @(posedge clk); #1;
    cmd_start = 0; cmd_addr = 16'($urandom); cmd_len = 5'($urandom); cmd_dir = 1'($urandom);
    for (int k = 0; k < 300; k++) begin
      if (done_n > db) begin tmo_g = 0; break; end
      if (BR) gcnt++; else gcnt = 0;
      if (!dropped && drop_len > 0 && (wr_n - wb) + (we_n - wbase) == drop_at) begin
        dropped = 1; dleft = drop_len;
      end
      if (dleft > 0 && !BR) brdrop_bad_g++;
      BG = BR && (gcnt > lat) && (dleft == 0);
      if (dleft > 0) dleft--;
      case (vmode)
        0:       dev_valid = 1'b1;
        1:       dev_valid = (k % 4 == 0) || (k % 4 == 3);
        default: dev_valid = 1'($urandom);
      endcase
      if (spur && k == lat + 2) begin
        cmd_start = 1; cmd_len = 5'd0; cmd_addr = 16'hDEAD;
      end else begin
        cmd_start = 0;
      end
      @(posedge clk); #1;
    end
    cmd_start = 0; BG = 0; dev_valid = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 0; cmd_start = 0; cmd_dir = 0; cmd_addr = 0; cmd_len = 0; BG = 0; dev_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({BR, busy, readM2, writeM2, dev_pop, dev_we, cmd_done} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0", {BR, busy, readM2, writeM2, dev_pop, dev_we, cmd_done});
    end
    checks++;
    if (address2 !== 16'h0 || dev_wdata !== 16'h0) begin
      errors++; $display("FAIL reset_data: address2=%h dev_wdata=%h want 0", address2, dev_wdata);
    end
    @(negedge clk); reset_n = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (BR !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: BR=%b busy=%b want 0", BR, busy);
    end
  endtask

  task automatic test_write_basic();
    int wb, db, vb, sb;
    wb = wr_n; db = done_n; vb = viol; sb = src_idx;
    for (int i = 0; i < 4; i++) src[sb + i] = 16'h00A1 + 16'(i);
    run_xfer(DIR_DEV2MEM, 16'h00C8, 4, 2, 0, 0, 0, 0);
    checks++;
    if (tmo_g) begin errors++; $display("FAIL wr1_timeout: no cmd_done"); end
    checks++;
    if (wr_n - wb != 4) begin errors++; $display("FAIL wr1_count: got %0d want 4", wr_n - wb); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_addr[wb + i] !== 16'h00C8 + 16'(i) || mem[16'h00C8 + 16'(i)] !== 16'h00A1 + 16'(i)) begin
        errors++; $display("FAIL wr1_word%0d: addr=%h mem=%h want %h/%h", i, wr_addr[wb + i],
                           mem[16'h00C8 + 16'(i)], 16'h00C8 + 16'(i), 16'h00A1 + 16'(i));
      end
    end
    checks++;
    if (wr_cyc[wb + 3] - wr_cyc[wb] != 3) begin
      errors++; $display("FAIL wr1_consec: span %0d want 3", wr_cyc[wb + 3] - wr_cyc[wb]);
    end
    checks++;
    if (done_n - db != 1 || done_cyc[db] != wr_cyc[wb + 3] + 1 || done_br[db] !== 1'b0) begin
      errors++; $display("FAIL wr1_done: n=%0d at %0d want 1 at %0d, BR=%b want 0",
                         done_n - db, done_cyc[db], wr_cyc[wb + 3] + 1, done_br[db]);
    end
    checks++;
    if (viol != vb || BR !== 1'b0) begin
      errors++; $display("FAIL wr1_protocol: viol=%0d BR=%b want 0/0", viol - vb, BR);
    end
  endtask

  task automatic test_read_basic();
    int eb, db, vb;
    logic [15:0] exp [0:2];
    exp[0] = 16'h9023; exp[1] = 16'h0001; exp[2] = 16'hFFFF;
    eb = we_n; db = done_n; vb = viol;
    run_xfer(DIR_MEM2DEV, 16'h0000, 3, 1, 0, 0, 0, 0);
    checks++;
    if (tmo_g || we_n - eb != 3) begin
      errors++; $display("FAIL rd_count: timeout=%0d dev_we=%0d want 0/3", tmo_g, we_n - eb);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (we_data[eb + i] !== exp[i]) begin
        errors++; $display("FAIL rd_word%0d: got %h want %h", i, we_data[eb + i], exp[i]);
      end
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (we_cyc[eb + i] - we_cyc[eb + i - 1] != 2) begin
        errors++; $display("FAIL rd_spacing%0d: got %0d want 2", i, we_cyc[eb + i] - we_cyc[eb + i - 1]);
      end
    end
    checks++;
    if (viol != vb || done_n - db != 1) begin
      errors++; $display("FAIL rd_protocol: viol=%0d done=%0d want 0/1", viol - vb, done_n - db);
    end
  endtask

  task automatic test_bg_drop();
    int wb, db, vb, sb;
    logic [15:0] w [0:4];
    wb = wr_n; db = done_n; vb = viol; sb = src_idx;
    for (int i = 0; i < 5; i++) begin w[i] = 16'($urandom); src[sb + i] = w[i]; end
    run_xfer(DIR_DEV2MEM, 16'h1100, 5, 1, 0, 2, 3, 0);
    checks++;
    if (tmo_g || wr_n - wb != 5 || done_n - db != 1) begin
      errors++; $display("FAIL drop_count: timeout=%0d writes=%0d done=%0d want 0/5/1", tmo_g, wr_n - wb, done_n - db);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wr_addr[wb + i] !== 16'h1100 + 16'(i) || wr_data[wb + i] !== w[i]) begin
        errors++; $display("FAIL drop_word%0d: %h:%h want %h:%h", i, wr_addr[wb + i], wr_data[wb + i],
                           16'h1100 + 16'(i), w[i]);
      end
    end
    checks++;
    if (wr_cyc[wb + 2] - wr_cyc[wb + 1] != 5) begin
      errors++; $display("FAIL drop_gap: got %0d want 5", wr_cyc[wb + 2] - wr_cyc[wb + 1]);
    end
    checks++;
    if (brdrop_bad_g != 0 || viol != vb) begin
      errors++; $display("FAIL drop_bus: BR-low=%0d viol=%0d want 0/0", brdrop_bad_g, viol - vb);
    end
  endtask

  task automatic test_wrap_and_zero();
    int wb, db, bb, sb;
    logic [15:0] w [0:2];
    logic [15:0] ea [0:2];
    ea[0] = 16'hFFFE; ea[1] = 16'hFFFF; ea[2] = 16'h0000;
    wb = wr_n; db = done_n; sb = src_idx;
    for (int i = 0; i < 3; i++) begin w[i] = 16'($urandom); src[sb + i] = w[i]; end
    run_xfer(DIR_DEV2MEM, 16'hFFFE, 3, 0, 0, 0, 0, 0);
    checks++;
    if (tmo_g || wr_n - wb != 3) begin
      errors++; $display("FAIL wrap_count: timeout=%0d writes=%0d want 0/3", tmo_g, wr_n - wb);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_addr[wb + i] !== ea[i] || mem[ea[i]] !== w[i]) begin
        errors++; $display("FAIL wrap_word%0d: addr=%h mem=%h want %h/%h", i, wr_addr[wb + i], mem[ea[i]], ea[i], w[i]);
      end
    end
    wb = wr_n; db = done_n; bb = br_n;
    run_xfer(DIR_DEV2MEM, 16'($urandom), 0, 0, 0, 0, 0, 0);
    checks++;
    if (tmo_g || done_n - db != 1 || done_cyc[db] - start_cyc != 1) begin
      errors++; $display("FAIL zero_done: timeout=%0d n=%0d delay=%0d want 0/1/1", tmo_g, done_n - db, done_cyc[db] - start_cyc);
    end
    checks++;
    if (br_n != bb || wr_n != wb) begin
      errors++; $display("FAIL zero_bus: BR cycles=%0d writes=%0d want 0/0", br_n - bb, wr_n - wb);
    end
  endtask

  task automatic test_valid_toggle();
    int wb, db, vb, sb;
    logic [15:0] w [0:5];
    wb = wr_n; db = done_n; vb = viol; sb = src_idx;
    for (int i = 0; i < 6; i++) begin w[i] = 16'($urandom); src[sb + i] = w[i]; end
    run_xfer(DIR_DEV2MEM, 16'h1200, 6, 0, 1, 0, 0, 0);
    checks++;
    if (tmo_g || wr_n - wb != 6 || done_n - db != 1) begin
      errors++; $display("FAIL valid_count: timeout=%0d writes=%0d done=%0d want 0/6/1", tmo_g, wr_n - wb, done_n - db);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (wr_addr[wb + i] !== 16'h1200 + 16'(i) || wr_data[wb + i] !== w[i]) begin
        errors++; $display("FAIL valid_word%0d: %h:%h want %h:%h", i, wr_addr[wb + i], wr_data[wb + i],
                           16'h1200 + 16'(i), w[i]);
      end
    end
    checks++;
    if (viol != vb) begin errors++; $display("FAIL valid_strobe: %0d bad cycles want 0", viol - vb); end
  endtask

  task automatic test_reset_mid_read();
    bit found, rd_prev;
    int gcnt, vb, eb, wb;
    found = 0; rd_prev = 0; gcnt = 0;
    @(posedge clk); #1;
    cmd_start = 1; cmd_dir = DIR_MEM2DEV; cmd_addr = 16'h8000; cmd_len = 5'd5; BG = 0;
    @(posedge clk); #1;
    cmd_start = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (BR) gcnt++; else gcnt = 0;
      BG = BR && gcnt > 1;
      @(negedge clk);
      if (readM2 && rd_prev) found = 1;
      else begin rd_prev = readM2; @(posedge clk); #1; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rst_reach: RD_D not reached, found=%0d want 1", found); end
    #2 reset_n = 0;
    #1;
    checks++;
    if ({BR, busy, readM2, writeM2, dev_pop, dev_we, cmd_done} !== 7'b0) begin
      errors++; $display("FAIL rst_async_ctrl: got %b want 0", {BR, busy, readM2, writeM2, dev_pop, dev_we, cmd_done});
    end
    checks++;
    if (address2 !== 16'h0 || dev_wdata !== 16'h0) begin
      errors++; $display("FAIL rst_async_data: address2=%h dev_wdata=%h want 0", address2, dev_wdata);
    end
    vb = viol; eb = we_n; wb = wr_n; BG = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2 reset_n = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (viol != vb || we_n != eb || wr_n != wb || BR !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_quiet: viol=%0d we=%0d wr=%0d BR=%b busy=%b want all 0",
                         viol - vb, we_n - eb, wr_n - wb, BR, busy);
    end
  endtask

  task automatic test_busy_ignore();
    int wb, db, sb;
    logic [15:0] w [0:3];
    wb = wr_n; db = done_n; sb = src_idx;
    for (int i = 0; i < 4; i++) begin w[i] = 16'($urandom); src[sb + i] = w[i]; end
    run_xfer(DIR_DEV2MEM, 16'h1300, 4, 1, 0, 0, 0, 1);
    checks++;
    if (tmo_g || wr_n - wb != 4 || done_n - db != 1) begin
      errors++; $display("FAIL busy_count: timeout=%0d writes=%0d done=%0d want 0/4/1", tmo_g, wr_n - wb, done_n - db);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_addr[wb + i] !== 16'h1300 + 16'(i) || wr_data[wb + i] !== w[i]) begin
        errors++; $display("FAIL busy_word%0d: %h:%h want %h:%h", i, wr_addr[wb + i], wr_data[wb + i],
                           16'h1300 + 16'(i), w[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int wb, eb, db, vb, sb, len, drop_at, drop_len, bad;
      logic dir;
      logic [15:0] a;
      logic [15:0] w [0:31];
      dir = 1'($urandom);
      len = $urandom_range(1, 31);
      drop_at = (len > 1) ? $urandom_range(1, len - 1) : 0;
      drop_len = (len > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
      a = (dir == DIR_MEM2DEV) ? 16'h8000 + 16'($urandom_range(0, 200)) : 16'h1400 + 16'(it * 64);
      wb = wr_n; eb = we_n; db = done_n; vb = viol; sb = src_idx; bad = 0;
      for (int i = 0; i < len; i++) begin w[i] = 16'($urandom); src[sb + i] = w[i]; end
      run_xfer(dir, a, len, $urandom_range(0, 4), 2, drop_at, drop_len, 0);
      checks++;
      if (tmo_g || done_n - db != 1 || viol != vb) begin
        errors++; $display("FAIL rnd%0d_ctrl: timeout=%0d done=%0d viol=%0d want 0/1/0", it, tmo_g, done_n - db, viol - vb);
      end
      checks++;
      if (dir == DIR_DEV2MEM) begin
        if (wr_n - wb != len || we_n != eb) bad++;
        for (int i = 0; i < len; i++)
          if (wr_addr[wb + i] !== a + 16'(i) || mem[a + 16'(i)] !== w[i]) bad++;
      end else begin
        if (we_n - eb != len || wr_n != wb) bad++;
        for (int i = 0; i < len; i++)
          if (we_data[eb + i] !== init_word(a + 16'(i))) bad++;
      end
      if (bad != 0) begin
        errors++; $display("FAIL rnd%0d_data: dir=%0d len=%0d words wrong=%0d want 0", it, dir, len, bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_bg_drop();
    test_wrap_and_zero();
    test_valid_toggle();
    test_reset_mid_read();
    test_busy_ignore();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
